// File: rtl/collect_2x1_dst_tag_seq_if.sv
// Bus bundle for the 2:1 tagged collector. Handshake: a word moves on a port only in a cycle
// where valid and ready are both high at the rising edge; valid never waits on ready.
interface collect_2x1_dst_tag_seq_if #(
    parameter int DATA_WIDTH            = 32,
    parameter int DESTINATION_TAG_WIDTH = 1,
    parameter int IN_COMMAND_WIDTH      = 1
);
    localparam int OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH + DESTINATION_TAG_WIDTH;

    logic                          i_en;
    logic [1:0]                    i_valid;
    logic [2*DATA_WIDTH-1:0]       i_data_bus;
    logic [2*IN_COMMAND_WIDTH-1:0] i_cmd;
    logic [1:0]                    o_ready;
    logic                          o_valid;
    logic [DATA_WIDTH-1:0]         o_data_bus;
    logic [OUT_COMMAND_WIDTH-1:0]  o_cmd;
    logic                          i_ready;

    modport slave (
        input  i_en, i_valid, i_data_bus, i_cmd, i_ready,
        output o_ready, o_valid, o_data_bus, o_cmd
    );

    modport master (
        output i_en, i_valid, i_data_bus, i_cmd, i_ready,
        input  o_ready, o_valid, o_data_bus, o_cmd
    );
endinterface

// File: rtl/collect_2x1_dst_tag_seq.sv
// Two-input round-robin collector into a 2-entry FIFO; each word is tagged with the input it came
// from (tag 1 = input 1) in the MSBs of the output command.
module collect_2x1_dst_tag_seq #(
    parameter int DATA_WIDTH            = 32,
    parameter int DESTINATION_TAG_WIDTH = 1,
    parameter int IN_COMMAND_WIDTH      = 1
) (
    input logic clk,
    input logic rst_n,
    collect_2x1_dst_tag_seq_if.slave bus
);
    localparam int OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH + DESTINATION_TAG_WIDTH;

    logic [DATA_WIDTH-1:0]        mem_data [2];
    logic [OUT_COMMAND_WIDTH-1:0] mem_cmd  [2];
    logic [1:0]                   count;
    logic                         rd_ptr;
    logic                         wr_ptr;
    logic                         rr_ptr;

    logic                         winner;
    logic                         any_valid;
    logic                         pop;
    logic                         acc;
    logic                         push;
    logic [1:0]                   grant;
    logic [DATA_WIDTH-1:0]        win_data;
    logic [IN_COMMAND_WIDTH-1:0]  win_cmd;

    assign any_valid = |bus.i_valid;
    assign pop       = bus.o_valid && bus.i_ready;
    // rst_n gating keeps o_ready low for the whole reset, not just after the first edge
    assign acc       = rst_n && bus.i_en && ((count != 2'd2) || pop);
    assign push      = acc && any_valid;

    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        if (bus.i_valid == 2'b11) begin
            winner = rr_ptr;
        end else begin
            winner = bus.i_valid[1];
        end
        if (any_valid) begin
            grant[winner] = 1'b1;
        end
    end

    assign bus.o_ready = acc ? grant : 2'b00;

    always_comb begin
        win_data = bus.i_data_bus[DATA_WIDTH-1:0];
        win_cmd  = bus.i_cmd[IN_COMMAND_WIDTH-1:0];
        if (winner) begin
            win_data = bus.i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];
            win_cmd  = bus.i_cmd[2*IN_COMMAND_WIDTH-1:IN_COMMAND_WIDTH];
        end
    end

    // Storage is not reset; count and pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= win_data;
            mem_cmd[wr_ptr]  <= {DESTINATION_TAG_WIDTH'(winner), win_cmd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            rr_ptr <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                rr_ptr <= ~winner;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.o_valid    = (count != 2'd0);
    assign bus.o_data_bus = bus.o_valid ? mem_data[rd_ptr] : '0;
    assign bus.o_cmd      = bus.o_valid ? mem_cmd[rd_ptr]  : '0;
endmodule

// File: tb/tb_collect_2x1_dst_tag_seq.sv
// Self-checking bench for the 2:1 tagged collector: a reference model predicts grants, and a
// scoreboard queue of {tag, cmd, data} is compared against every output word.
module tb_collect_2x1_dst_tag_seq;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [DW+1:0] exp_q[$];
    logic          tb_rr;
    logic [1:0]    last_grant;

    collect_2x1_dst_tag_seq_if #(.DATA_WIDTH(DW), .DESTINATION_TAG_WIDTH(1), .IN_COMMAND_WIDTH(1)) bus ();

    collect_2x1_dst_tag_seq #(
        .DATA_WIDTH(DW),
        .DESTINATION_TAG_WIDTH(1),
        .IN_COMMAND_WIDTH(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive at the negedge, check at +1, model the edge, return at the next negedge.
    task automatic step(input logic [1:0] v, input logic en, input logic rdy,
                        input logic [DW-1:0] dh, input logic [DW-1:0] dl, input logic [1:0] c);
        logic          acc;
        logic          w;
        logic [1:0]    exp_rdy;
        logic [DW+1:0] e;
        bus.i_valid    = v;
        bus.i_en       = en;
        bus.i_ready    = rdy;
        bus.i_data_bus = {dh, dl};
        bus.i_cmd      = c;
        #1;
        acc     = en && (exp_q.size() < 2 || (exp_q.size() != 0 && rdy));
        w       = (v == 2'b11) ? tb_rr : v[1];
        exp_rdy = 2'b00;
        if (acc && v != 2'b00) exp_rdy[w] = 1'b1;
        checks++;
        if (bus.o_ready !== exp_rdy) begin
            errors++;
            $display("FAIL o_ready: got %b expected %b at %0t", bus.o_ready, exp_rdy, $time);
        end
        checks++;
        if (bus.o_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL o_valid: got %b expected %b at %0t", bus.o_valid, exp_q.size() != 0, $time);
        end
        checks++;
        if (exp_q.size() != 0) begin
            if ({bus.o_cmd, bus.o_data_bus} !== exp_q[0]) begin
                errors++;
                $display("FAIL out_word: got %h expected %h at %0t", {bus.o_cmd, bus.o_data_bus}, exp_q[0], $time);
            end
        end else if ({bus.o_cmd, bus.o_data_bus} !== '0) begin
            errors++;
            $display("FAIL idle_zero: got %h expected 0 at %0t", {bus.o_cmd, bus.o_data_bus}, $time);
        end
        last_grant = exp_rdy;
        @(posedge clk);
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (acc && v != 2'b00) begin
            e = {w, (w ? c[1] : c[0]), (w ? dh : dl)};
            exp_q.push_back(e);
            tb_rr = ~w;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.i_en       = 1'b1;
        bus.i_valid    = 2'b11;
        bus.i_ready    = 1'b0;
        bus.i_data_bus = '1;
        bus.i_cmd      = 2'b11;
        exp_q.delete();
        tb_rr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_cmd, bus.o_data_bus} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%b c=%b d=%h expected all 0",
                     bus.o_valid, bus.o_ready, bus.o_cmd, bus.o_data_bus);
        end
        bus.i_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step(2'b01, 1'b1, 1'b1, 32'h0, 32'hAAAAAAAA, 2'b10);
        checks++;
        if (last_grant !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b expected 01", last_grant);
        end
        #1;
        checks++;
        if ({bus.o_valid, bus.o_cmd, bus.o_data_bus} !== {1'b1, 2'b00, 32'hAAAAAAAA}) begin
            errors++;
            $display("FAIL single_out: got v=%b c=%b d=%h expected v=1 c=00 d=aaaaaaaa",
                     bus.o_valid, bus.o_cmd, bus.o_data_bus);
        end
        step(2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic test_contention();
        logic [1:0] exp_g[4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b1, 1'b1, 32'hBBBBBBBB, 32'hAAAAAAAA, 2'b01);
            checks++;
            if (last_grant !== exp_g[i]) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b expected %b", i, last_grant, exp_g[i]);
            end
        end
        repeat (2) step(2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic test_full_passthrough();
        for (int i = 0; i < 3; i++)
            step(2'b11, 1'b1, 1'b0, 32'h1000 + i, 32'h2000 + i, 2'(i));
        checks++;
        if (last_grant !== 2'b00) begin
            errors++;
            $display("FAIL full_blocks: got %b expected 00", last_grant);
        end
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b1, 1'b1, 32'h3000 + i, 32'h4000 + i, 2'(i));
            checks++;
            if (last_grant == 2'b00 || bus.o_valid !== 1'b1) begin
                errors++;
                $display("FAIL passthrough%0d: got grant=%b o_valid=%b expected a grant with o_valid=1",
                         i, last_grant, bus.o_valid);
            end
        end
    endtask

    task automatic test_drain_disabled();
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b0, 1'b1, 32'h5000 + i, 32'h6000 + i, 2'b11);
            checks++;
            if (last_grant !== 2'b00) begin
                errors++;
                $display("FAIL drain_no_accept%0d: got %b expected 00", i, last_grant);
            end
        end
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_data_bus !== '0) begin
            errors++;
            $display("FAIL drain_empty: got v=%b d=%h expected v=0 d=0", bus.o_valid, bus.o_data_bus);
        end
    endtask

    task automatic test_reset_mid_burst();
        repeat (2) step(2'b11, 1'b1, 1'b0, 32'h7777, 32'h8888, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_data_bus !== '0 || bus.o_ready !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h r=%b expected 0/0/00",
                     bus.o_valid, bus.o_data_bus, bus.o_ready);
        end
        exp_q.delete();
        tb_rr = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b11, 1'b1, 1'b1, 32'h9999, 32'hCCCC, 2'b00);
        checks++;
        if (last_grant !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_grant: got %b expected 10", last_grant);
        end
        step(2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 $urandom, $urandom, 2'($urandom_range(0, 3)));
        repeat (3) step(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 2'b00);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_full_passthrough();
        test_drain_disabled();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/collect_2x1_dst_tag_seq.md
COLLECT_2X1_DST_TAG_SEQ -- requirements
Module: collect_2x1_dst_tag_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each data word.
REQ-002 SHALL have parameter DESTINATION_TAG_WIDTH, default 1, source-tag bits prepended per stage.
REQ-003 SHALL have parameter IN_COMMAND_WIDTH, default 1, command width carried per input.
REQ-004 SHALL derive localparam OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH + DESTINATION_TAG_WIDTH.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 i_en  input  1  stage enable; gates acceptance only.
REQ-009 i_valid  input  2  per-input valid; bit1 = high input, bit0 = low input.
REQ-010 i_data_bus  input  2*DATA_WIDTH  high word [2*DATA_WIDTH-1:DATA_WIDTH], low word [DATA_WIDTH-1:0].
REQ-011 i_cmd  input  2*IN_COMMAND_WIDTH  per-input command; high slice belongs to input 1.
REQ-012 o_ready  output  2  per-input accept; transfer on i_valid[k] && o_ready[k].
REQ-013 o_valid  output  1  output word valid.
REQ-014 o_data_bus  output  DATA_WIDTH  output word.
REQ-015 o_cmd  output  OUT_COMMAND_WIDTH  {source tag, forwarded command}.
REQ-016 i_ready  input  1  downstream accept; pop on o_valid && i_ready.

Function
REQ-017 SHALL store accepted words in a 2-entry FIFO of {tag, cmd, data}, count 0..2, 1-bit wrapping read/write pointers.
REQ-018 SHALL define pop = o_valid && i_ready and acc = i_en && (count<2 || pop).
REQ-019 SHALL grant the sole valid input when one is valid; when both are valid, grant input rr_ptr.
REQ-020 SHALL drive o_ready[k] = acc && grant[k] combinationally; at most one bit high per cycle.
REQ-021 SHALL set rr_ptr <= ~winner on every accepted transfer; rr_ptr holds otherwise.
REQ-022 SHALL set tag = 1 for input 1 and tag = 0 for input 0 (inverse of the 1x2 distributor's MSB steering).
REQ-023 SHALL present o_cmd = {tag, winner's IN_COMMAND_WIDTH cmd slice}, tag in MSB.
REQ-024 SHALL assert o_valid = (count != 0) and drive o_data_bus/o_cmd from the head entry; all zero when count == 0.
REQ-025 SHALL have 1-cycle latency: a word accepted at edge N is visible on o_valid after edge N when the FIFO is empty.
REQ-026 SHALL keep count unchanged on simultaneous push and pop, including count == 2 (full pass-through).
REQ-027 SHALL keep count and contents unchanged when neither push nor pop occurs.
REQ-028 SHALL preserve acceptance order at the output; no drop, no duplication.
REQ-029 SHALL continue draining with i_en = 0; only acceptance stops, and rr_ptr holds.
REQ-030 SHALL hold o_valid, o_data_bus and o_cmd stable while o_valid && !i_ready.

Reset
REQ-031 SHALL on rst_n = 0 immediately clear count, both pointers, o_valid, o_data_bus, o_cmd and o_ready.
REQ-032 SHALL reset rr_ptr to 1, so input 1 wins the first contended grant.
REQ-033 SHALL discard all stored entries on reset mid-operation; storage RAM need not be cleared.
REQ-034 SHALL begin accepting on the first rising edge after rst_n deasserts, given i_en = 1.

Verification
REQ-035 Reset, i_en=1, i_valid=2'b01, low word 32'hAAAAAAAA, cmd 2'b10, i_ready=1 -> o_ready=2'b01; next cycle o_valid=1, o_data_bus=32'hAAAAAAAA, o_cmd=2'b00.
REQ-036 Both valid for 4 cycles, high 32'hBBBBBBBB, low 32'hAAAAAAAA, i_ready=1 -> grants 1,0,1,0; output BB,AA,BB,AA with tags 1,0,1,0.
REQ-037 i_ready=0, both valid -> two words accepted, then o_ready=2'b00 with count=2; i_ready=1 with both valid -> one pop and one push per cycle, count stays 2.
REQ-038 FIFO holding 2 words, i_en=0, i_ready=1 -> o_ready=2'b00, two words drain in order, then o_valid=0 and o_data_bus=0.
REQ-039 rst_n=0 asserted mid-burst, between clock edges, with count=2 -> o_valid=0 and o_data_bus=0 without waiting for a clock edge; after release, the first contended grant goes to input 1.
